shim_cfg_stable_latch: RTL and testbench

Parametrised, single-clock configuration qualifier in the SPI domain. It sits directly after the per-bit synchronisers on the config path. Each of NUM_FIELDS fields is admitted to dout only after its bits have held one value for STABLE_CYCLES. This gives word-coherent config without a handshake. A lock input freezes committed values while the shim is running, and changes seen during lock are deferred and reported.

---
 rtl/shim_cfg_pkg.sv | 22 ++
 rtl/shim_cfg_field_qual.sv | 115 +++++++++++
 rtl/shim_cfg_stable_latch.sv | 115 +++++++++++
 tb/tb_shim_cfg_stable_latch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shim_cfg_pkg.sv
// Shared definitions for the SPI-domain config stability shim.
// Holds the per-field state encoding, the defaults shared with the AXI
// cfg block, and the bit-offset helper used to pack and unpack field i
// on the flat NUM_FIELDS*FIELD_W buses.
package shim_cfg_pkg;

    typedef enum logic [1:0] {
        STABLE  = 2'd0,
        SETTLE  = 2'd1,
        PENDING = 2'd2
    } field_state_e;

    localparam logic [14:0] INTEG_THRESH_AVG_DEFAULT = 15'h1000;
    localparam logic [31:0] INTEG_WINDOW_DEFAULT     = 32'h0001_0000;

    // LSB position of field idx on a flat bus of width-bit fields.
    function automatic int unsigned field_lsb(input int unsigned idx,
                                              input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/shim_cfg_field_qual.sv
// One config field qualifier: tracks a candidate value and how long din
// has matched it, and requests a commit once it has been steady for
// STABLE_CYCLES consecutive samples. The committed value itself lives in
// the top level; this block only decides when to take it.
// Optional build macro: SHIM_CFG_ATOMIC_COMMIT_EN (adds ready_o).
module shim_cfg_field_qual
    import shim_cfg_pkg::*;
#(
    parameter int unsigned FIELD_W       = 32,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FIELD_W-1:0] din,
    input  logic [FIELD_W-1:0] din_default,
    input  logic [FIELD_W-1:0] dout_cur,
    input  logic               valid_cur,
    input  logic               commit_en,
    output logic [FIELD_W-1:0] cand_o,
    output logic               commit_o,
    output logic               blocked_o,
`ifdef SHIM_CFG_ATOMIC_COMMIT_EN
    output logic               ready_o,
`endif
    output logic               pending_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    field_state_e       state_q, state_d;
    logic [FIELD_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               din_diff;
    logic               at_final;
    logic               need_commit;

    assign din_diff    = (din != cand_q);
    assign at_final    = (cnt_q == CNT_LAST);
    // Before the first commit the candidate always commits, even when it
    // equals the reset default, so dout_valid can rise.
    assign need_commit = (cand_q != dout_cur) || !valid_cur;

`ifdef SHIM_CFG_ATOMIC_COMMIT_EN
    // Field will not be in SETTLE after this edge; independent of commit_en.
    assign ready_o = !din_diff && ((state_q != SETTLE) || at_final);
`endif

    // Next-state, candidate and settle-counter logic.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        commit_o  = 1'b0;
        blocked_o = 1'b0;
        case (state_q)
            STABLE: begin
                if (din_diff) begin
                    cand_d  = din;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (din_diff) begin
                    cand_d = din;
                    cnt_d  = '0;
                end else if (at_final) begin
                    if (!need_commit) begin
                        state_d = STABLE;
                    end else if (commit_en) begin
                        commit_o = 1'b1;
                        state_d  = STABLE;
                    end else begin
                        blocked_o = 1'b1;
                        state_d   = PENDING;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PENDING: begin
                if (din_diff) begin
                    cand_d  = din;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (commit_en) begin
                    commit_o = 1'b1;
                    state_d  = STABLE;
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    // State registers; reset discards any candidate in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE;
            cand_q  <= din_default;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cand_o    = cand_q;
    assign pending_o = (state_q == PENDING);

endmodule

// File: rtl/shim_cfg_stable_latch.sv
// Config stability shim: admits each field of din to dout only after it
// has held one value for STABLE_CYCLES samples, holds commits while lock
// is high, and flags qualifications that lock blocked.
// Optional build macro: SHIM_CFG_ATOMIC_COMMIT_EN -- all fields commit as
// one group once none is settling and lock is low.
module shim_cfg_stable_latch
    import shim_cfg_pkg::*;
#(
    parameter int unsigned NUM_FIELDS    = 4,
    parameter int unsigned FIELD_W       = 32,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FIELDS*FIELD_W-1:0] din,
    input  logic [NUM_FIELDS*FIELD_W-1:0] din_default,
    input  logic                          lock,
    output logic [NUM_FIELDS*FIELD_W-1:0] dout,
    output logic [NUM_FIELDS-1:0]         dout_valid,
    output logic [NUM_FIELDS-1:0]         update,
    output logic [NUM_FIELDS-1:0]         pending,
    output logic                          lock_violation,
    input  logic                          violation_clear
);

    logic [NUM_FIELDS*FIELD_W-1:0] dout_q, dout_d;
    logic [NUM_FIELDS*FIELD_W-1:0] cand_bus;
    logic [NUM_FIELDS-1:0]         valid_q, valid_d;
    logic [NUM_FIELDS-1:0]         update_q, update_d;
    logic [NUM_FIELDS-1:0]         commit;
    logic [NUM_FIELDS-1:0]         blocked;
    logic [NUM_FIELDS-1:0]         commit_en;
    logic                          viol_q, viol_d;

`ifdef SHIM_CFG_ATOMIC_COMMIT_EN
    logic [NUM_FIELDS-1:0] ready;
    logic                  group_go;

    assign group_go  = !lock && (&ready);
    assign commit_en = {NUM_FIELDS{group_go}};
`else
    assign commit_en = {NUM_FIELDS{!lock}};
`endif

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        shim_cfg_field_qual #(
            .FIELD_W      (FIELD_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_qual (
            .clk        (clk),
            .reset      (reset),
            .din        (din[field_lsb(i, FIELD_W) +: FIELD_W]),
            .din_default(din_default[field_lsb(i, FIELD_W) +: FIELD_W]),
            .dout_cur   (dout_q[field_lsb(i, FIELD_W) +: FIELD_W]),
            .valid_cur  (valid_q[i]),
            .commit_en  (commit_en[i]),
            .cand_o     (cand_bus[field_lsb(i, FIELD_W) +: FIELD_W]),
            .commit_o   (commit[i]),
            .blocked_o  (blocked[i]),
`ifdef SHIM_CFG_ATOMIC_COMMIT_EN
            .ready_o    (ready[i]),
`endif
            .pending_o  (pending[i])
        );
    end

    // Commit qualified candidates into dout with a one-cycle update pulse.
    always_comb begin
        dout_d   = dout_q;
        valid_d  = valid_q;
        update_d = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (commit[i]) begin
                dout_d[field_lsb(i, FIELD_W) +: FIELD_W] =
                    cand_bus[field_lsb(i, FIELD_W) +: FIELD_W];
                valid_d[i]  = 1'b1;
                update_d[i] = 1'b1;
            end
        end
    end

    // Sticky lock-violation flag; a new violation beats a same-cycle clear.
    always_comb begin
        viol_d = viol_q;
        if (violation_clear) begin
            viol_d = 1'b0;
        end
        if (lock && (|blocked)) begin
            viol_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q   <= din_default;
            valid_q  <= '0;
            update_q <= '0;
            viol_q   <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            viol_q   <= viol_d;
        end
    end

    assign dout           = dout_q;
    assign dout_valid     = valid_q;
    assign update         = update_q;
    assign lock_violation = viol_q;

endmodule

// File: tb/tb_shim_cfg_stable_latch.sv
// Directed bench for shim_cfg_stable_latch (4 fields x 32 bits, 4-cycle
// settle). Inputs change 1 ns after a rising edge; outputs are checked at
// the same point, i.e. they reflect the edge just taken.
module tb_shim_cfg_stable_latch;
    import shim_cfg_pkg::*;

    localparam int unsigned NF = 4;
    localparam int unsigned FW = 32;

    localparam logic [NF*FW-1:0] DEF = {32'h0000_0033, 32'h0, 32'h0,
                                        INTEG_WINDOW_DEFAULT};

    logic             clk;
    logic             reset;
    logic [NF*FW-1:0] din;
    logic [NF*FW-1:0] din_default;
    logic             lock;
    logic [NF*FW-1:0] dout;
    logic [NF-1:0]    dout_valid;
    logic [NF-1:0]    update;
    logic [NF-1:0]    pending;
    logic             lock_violation;
    logic             violation_clear;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        upd2_seen;

    shim_cfg_stable_latch #(
        .NUM_FIELDS   (NF),
        .FIELD_W      (FW),
        .STABLE_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .din_default    (din_default),
        .lock           (lock),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .update         (update),
        .pending        (pending),
        .lock_violation (lock_violation),
        .violation_clear(violation_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] fld(input logic [NF*FW-1:0] bus,
                                          input int unsigned i);
        return bus[i*FW +: FW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        din             = DEF;
        din_default     = DEF;
        lock            = 1'b0;
        violation_clear = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dout0", fld(dout, 0), 32'h0001_0000);
        chk("rst_dout3", fld(dout, 3), 32'h0000_0033);
        chk("rst_valid", dout_valid, 4'b0000);
        chk("rst_update", update, 4'b0000);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_viol", lock_violation, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_rst_update", update, 4'b0000);
        chk("post_rst_dout", dout, DEF);

        // Field1 0 -> A5: commits on the 5th edge, one-cycle update
        din[1*FW +: FW] = 32'hA5;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("f1_settling_dout", fld(dout, 1), 32'h0);
            chk("f1_settling_upd", update, 4'b0000);
        end
        tick();
        chk("f1_commit_dout", fld(dout, 1), 32'hA5);
        chk("f1_commit_upd", update, 4'b0010);
        chk("f1_commit_valid", dout_valid, 4'b0010);
        tick();
        chk("f1_upd_one_cycle", update, 4'b0000);
        chk("f1_hold_dout", fld(dout, 1), 32'hA5);

        // Glitch of exactly 4 edges on a committed field never lands
        din[1*FW +: FW] = 32'h5A;
        for (int k = 0; k < 4; k++) tick();
        din[1*FW +: FW] = 32'hA5;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("f1_glitch_upd", update, 4'b0000);
        end
        chk("f1_glitch_dout", fld(dout, 1), 32'hA5);

        // Field2 toggles every 3 cycles for 40 cycles: never qualifies
        upd2_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            din[2*FW +: FW] = (((c / 3) % 2) == 0) ? 32'h1 : 32'h2;
            tick();
            if (update[2]) upd2_seen = 1'b1;
        end
        chk("f2_toggle_upd_seen", upd2_seen, 1'b0);
        chk("f2_toggle_dout", fld(dout, 2), 32'h0);
        // Back to the default value: first qualification still commits
        din[2*FW +: FW] = 32'h0;
        for (int k = 0; k < 4; k++) tick();
        chk("f2_def_wait_upd", update, 4'b0000);
        tick();
        chk("f2_def_commit_upd", update, 4'b0100);
        chk("f2_def_valid", dout_valid, 4'b0110);
        chk("f2_def_dout", fld(dout, 2), 32'h0);

        // Lock holds field0; qualification is reported then deferred
        lock = 1'b1;
        din[0*FW +: FW] = 32'h1234;
        for (int k = 0; k < 4; k++) tick();
        chk("lock_not_yet_pend", pending, 4'b0000);
        tick();
        chk("lock_pend", pending, 4'b0001);
        chk("lock_viol_set", lock_violation, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("lock_pend_hold", pending, 4'b0001);
        chk("lock_dout_hold", fld(dout, 0), 32'h0001_0000);
        chk("lock_no_upd", update, 4'b0000);
        lock = 1'b0;
        tick();
        chk("unlock_dout", fld(dout, 0), 32'h1234);
        chk("unlock_upd", update, 4'b0001);
        chk("unlock_pend", pending, 4'b0000);
        chk("unlock_viol_sticky", lock_violation, 1'b1);
        violation_clear = 1'b1;
        tick();
        violation_clear = 1'b0;
        chk("viol_cleared", lock_violation, 1'b0);

        // Reset two edges into a field3 settle
        din[3*FW +: FW] = 32'h99;
        tick();
        tick();
        reset = 1'b1;
        din[0*FW +: FW] = fld(DEF, 0);
        din[1*FW +: FW] = fld(DEF, 1);
        tick();
        chk("mid_rst_dout", dout, DEF);
        chk("mid_rst_valid", dout_valid, 4'b0000);
        chk("mid_rst_pend", pending, 4'b0000);
        chk("mid_rst_upd", update, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("f3_resettle_upd", update, 4'b0000);
            chk("f3_resettle_dout", fld(dout, 3), 32'h33);
        end
        tick();
        chk("f3_commit_upd", update, 4'b1000);
        chk("f3_commit_dout", fld(dout, 3), 32'h99);
        chk("f3_commit_valid", dout_valid, 4'b1000);

`ifdef SHIM_CFG_ATOMIC_COMMIT_EN
        // Group commit: field0 waits in PENDING until field1 qualifies
        tick();
        din[0*FW +: FW] = 32'h11;
        tick();
        tick();
        tick();
        din[1*FW +: FW] = 32'h22;
        tick();
        tick();
        chk("atom_f0_pend", pending, 4'b0001);
        chk("atom_f0_held", fld(dout, 0), fld(DEF, 0));
        tick();
        tick();
        chk("atom_wait_upd", update, 4'b0000);
        tick();
        chk("atom_upd_both", update, 4'b0011);
        chk("atom_dout0", fld(dout, 0), 32'h11);
        chk("atom_dout1", fld(dout, 1), 32'h22);
        chk("atom_pend_clear", pending, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
